// File: rtl/bus_pkg.sv
// Shared definitions for the serial burst slave: state encoding and default parameters.
package bus_pkg;

    localparam int unsigned DefAddrWidth   = 12;
    localparam int unsigned DefDataWidth   = 8;
    localparam int unsigned DefMemSize     = 4096;
    localparam int unsigned DefBurstWidth  = 4;
    localparam int unsigned DefReadLatency = 2;
    localparam bit          DefSplitEn     = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWdata,
        StWcommit,
        StRfetch,
        StSplit,
        StRdata
    } state_e;

    // Largest of three values, used to size the shared bit/cycle counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/slave_mem_lat.sv
// Synchronous word RAM with a READ_LATENCY-deep read pipeline.
// The last pipeline stage holds its data until a newer read reaches it.
module slave_mem_lat import bus_pkg::*; #(
    parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned MEM_SIZE     = DefMemSize,
    parameter int unsigned READ_LATENCY = DefReadLatency
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    logic [DATA_WIDTH-1:0]   mem_q [MEM_SIZE];
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    // Storage array: never reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read pipeline: reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= ren;
            if (ren) begin
                dat_q[0] <= mem_q[addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rdata  = dat_q[READ_LATENCY-1];
    assign rvalid = vld_q[READ_LATENCY-1];

endmodule

// File: rtl/burst_slave.sv
// Bit-serial burst slave: serial header (address, length), serial write data,
// serial read data with optional bus split while the first read is fetched.
module burst_slave import bus_pkg::*; #(
    parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned MEM_SIZE     = DefMemSize,
    parameter int unsigned BURST_WIDTH  = DefBurstWidth,
    parameter int unsigned READ_LATENCY = DefReadLatency,
    parameter bit          SPLIT_EN     = DefSplitEn
) (
    input  logic clk,
    input  logic rstn,
    input  logic swdata,
    input  logic smode,
    input  logic mvalid,
    input  logic split_grant,
    output logic srdata,
    output logic svalid,
    output logic sready,
    output logic ssplit
);

    localparam int unsigned HdrLen = ADDR_WIDTH + BURST_WIDTH;
    localparam int unsigned CntW   = $clog2(max3(HdrLen, DATA_WIDTH, READ_LATENCY) + 1);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_SIZE - 1);

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [HdrLen-1:0]      hdr_q, hdr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BURST_WIDTH-1:0] len_q, len_d;
    logic [BURST_WIDTH-1:0] beat_q, beat_d;
    logic [DATA_WIDTH-1:0]  wbuf_q, wbuf_d;
    logic                   rdy_q, rdy_d;

    logic                   mem_wen, mem_ren, mem_rvalid;
    logic [DATA_WIDTH-1:0]  mem_rdata, rshift;
    logic [HdrLen-1:0]      hdr_shift;
    logic [ADDR_WIDTH-1:0]  hdr_addr, addr_inc;

    // Header bits arrive LSB first, so shift in at the top.
    assign hdr_shift = {swdata, hdr_q[HdrLen-1:1]};
    assign hdr_addr  = ADDR_WIDTH'(32'(hdr_shift[ADDR_WIDTH-1:0]) % MEM_SIZE);
    assign addr_inc  = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
    assign rshift    = mem_rdata >> cnt_q;

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wbuf_d  = wbuf_q;
        rdy_d   = rdy_q;
        mem_wen = 1'b0;
        mem_ren = 1'b0;
        sready  = 1'b0;
        svalid  = 1'b0;
        srdata  = 1'b0;
        ssplit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                sready = 1'b1;
                if (mvalid) begin
                    mode_d  = smode;
                    hdr_d   = hdr_shift;
                    cnt_d   = CntW'(1);
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (!mvalid) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    hdr_d = hdr_shift;
                    if (cnt_q == CntW'(HdrLen - 1)) begin
                        addr_d  = hdr_addr;
                        len_d   = hdr_shift[HdrLen-1 -: BURST_WIDTH];
                        beat_d  = '0;
                        cnt_d   = '0;
                        state_d = mode_q ? StWdata : StRfetch;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWdata: begin
                if (!mvalid) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    wbuf_d = {swdata, wbuf_q[DATA_WIDTH-1:1]};
                    if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = StWcommit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWcommit: begin
                mem_wen = 1'b1;
                if (beat_q == len_q) begin
                    state_d = StIdle;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    addr_d  = addr_inc;
                    state_d = StWdata;
                end
            end
            StRfetch: begin
                mem_ren = (cnt_q == '0);
                // Only the first beat of a burst may release the bus.
                if (SPLIT_EN && beat_q == '0) begin
                    ssplit  = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = StSplit;
                end else if (cnt_q == CntW'(READ_LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = StRdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSplit: begin
                ssplit = 1'b1;
                rdy_d  = rdy_q | mem_rvalid;
                if (split_grant && (rdy_q || mem_rvalid)) begin
                    rdy_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRdata;
                end
            end
            StRdata: begin
                svalid = 1'b1;
                srdata = rshift[0];
                if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                    cnt_d = '0;
                    if (beat_q == len_q) begin
                        state_d = StIdle;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        addr_d  = addr_inc;
                        state_d = StRfetch;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            hdr_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wbuf_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wbuf_q  <= wbuf_d;
            rdy_q   <= rdy_d;
        end
    end

    slave_mem_lat #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .MEM_SIZE    (MEM_SIZE),
        .READ_LATENCY(READ_LATENCY)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .wen   (mem_wen),
        .ren   (mem_ren),
        .addr  (addr_q),
        .wdata (wbuf_q),
        .rdata (mem_rdata),
        .rvalid(mem_rvalid)
    );

endmodule
